mc_ctrl: RTL and testbench
==========================

// Module: mc_ctrl
// PURPOSE
//  Multi-cycle main controller for the MIPS-lite core. Decodes the latched instruction and sequences
//  IF/ID/EXE/MEM/WB. Drives ALUOp (000 add, 001 sub, 010 or, 011 slt, 100 addi, 101 bgezal) into the alu.
//  Consumes the alu's zero, overflow and condition_jdg flags to resolve branches and addi overflow.
// PARAMETERS
//  RA_REG   31  link register index written by bgezal
//  OVF_REG  30  flag register index written on addi overflow (MC_CTRL_OVF_FLAG_EN only)
// PORTS
//  clk            in   1  clock, all state updates on rising edge
//  rst            in   1  reset, synchronous, active-high
//  opcode         in   6  IR[31:26]
//  funct          in   6  IR[5:0]
//  rt             in   5  IR[20:16] (bgezal: opcode 000001, rt 10001)
//  zero           in   1  alu A==B
//  overflow       in   1  alu addi signed overflow
//  condition_jdg  in   1  alu A>=0 (valid while ALUOp=101)
//  pc_write       out  1  PC load enable
//  pc_src         out  2  00 PC+4, 01 branch target, 10 jump target
//  ir_write       out  1  IR load enable
//  reg_write      out  1  regfile write enable
//  reg_dst        out  2  00 rt, 01 rd, 10 RA_REG, 11 OVF_REG
//  mem_to_reg     out  2  00 ALUOut, 01 MDR, 10 PC(+4, link), 11 constant 1
//  alu_src_b      out  2  00 reg B, 01 sign-ext imm, 10 zero-ext imm
//  alu_op         out  3  to alu ALUOp
//  mem_read       out  1  data memory read
//  mem_write      out  1  data memory write
//  instr_done     out  1  one-cycle pulse in the last cycle of each instruction
//  state          out  3  current state, for debug/bench
// BEHAVIOUR
//  States: IF=0, ID=1, EXE=2, MEM=3, WB=4, MWB=5. Outputs decode combinationally from state, opcode, flags.
//  Reset: state<=IF at the edge sampling rst=1. While rst=1, every output above is forced to 0, and a write
//   sequence in progress is abandoned with no write enable asserted.
//  IF: ir_write=1, pc_write=1, pc_src=00 -> ID.
//  ID: j (000010): pc_write=1, pc_src=10, instr_done -> IF.
//   Undefined opcode or undefined R funct: no enables, instr_done -> IF.
//   All other instructions -> EXE.
//  EXE: R addu(100001)/subu(100011)/slt(101010): alu_src_b=00, alu_op=000/001/011 -> WB.
//   ori: alu_src_b=10, op 010 -> WB. addi: alu_src_b=01, op 100; ovf_q<=overflow -> WB.
//   lw/sw: alu_src_b=01, op 000 -> MEM.
//   beq: alu_src_b=00, op 001; zero=1 -> pc_write=1, pc_src=01; instr_done -> IF.
//   bgezal: op 101; condition_jdg=1 -> pc_write=1, pc_src=01, reg_write=1, reg_dst=10, mem_to_reg=10;
//    instr_done -> IF.
//  MEM: lw -> mem_read=1 -> MWB. sw -> mem_write=1, instr_done -> IF.
//  MWB: reg_write=1, reg_dst=00, mem_to_reg=01, instr_done -> IF.
//  WB: reg_write=1, mem_to_reg=00, reg_dst=01 for R-type and 00 for I-type; instr_done -> IF.
//   addi with ovf_q=1: see CONFIGURATION.
//  Latency in cycles, IF through instr_done: j 2, beq/bgezal 3, R/ori/addi/sw 4, lw 5.
//  Flags are sampled only in EXE; alu_op is held at 000 in every other state.
//  ovf_q is cleared by rst and in IF.
//  alu_op is 101 only for bgezal, so condition_jdg is ignored outside bgezal EXE.
// CONFIGURATION
//  MC_CTRL_OVF_FLAG_EN undefined: addi with ovf_q=1 -> WB asserts no reg_write (result discarded).
//  MC_CTRL_OVF_FLAG_EN defined: addi with ovf_q=1 -> WB asserts reg_write=1, reg_dst=11, mem_to_reg=11,
//   i.e. writes 1 to register OVF_REG and leaves rt unchanged.
//  Non-overflow behaviour is identical in both builds.
// TESTING
//  addu (op 0, funct 100001) from reset -> states 0,1,2,4; alu_op=000 in EXE; reg_write/reg_dst=01 in WB;
//   instr_done in cycle 4.
//  lw (100011) -> 0,1,2,3,5; mem_read only in 3; reg_write + mem_to_reg=01 only in 5.
//   sw (101011) -> mem_write in 3, done.
//  beq: zero=1 -> pc_write=1, pc_src=01 in EXE. zero=0 -> no pc_write in EXE. Both done in 3 cycles.
//  bgezal, condition_jdg=1 -> EXE pc_write=1, reg_write=1, reg_dst=10, mem_to_reg=10.
//   condition_jdg=0 -> none asserted.
//  addi with overflow=1 in EXE -> WB reg_write=0 (macro off), or reg_write=1, reg_dst=11, mem_to_reg=11
//   (macro on). overflow=0 -> rt written.
//  rst=1 mid-lw in MEM -> mem_read=0 that cycle, state=0 next, no reg_write.
//   Undefined opcode 111111 -> IF after ID.

Source files
------------

// File: rtl/mc_ctrl.sv
// Multi-cycle main controller for the MIPS-lite core: IF/ID/EXE/MEM/WB/MWB sequencing and ALU op decode.
// Optional build macro MC_CTRL_OVF_FLAG_EN: addi overflow writes 1 to OVF_REG (30) instead of discarding.
module mc_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic [4:0] rt,
  input  logic       zero,
  input  logic       overflow,
  input  logic       condition_jdg,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       mem_read,
  output logic       mem_write,
  output logic       instr_done,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4,
    S_MWB = 3'd5
  } state_t;

  state_t state_q, state_d;
  logic   ovf_q;

  logic is_r, is_addu, is_subu, is_slt, r_valid;
  logic is_j, is_beq, is_bgezal, is_ori, is_addi, is_lw, is_sw, valid;

  assign is_r      = (opcode == 6'b000000);
  assign is_addu   = is_r && (funct == 6'b100001);
  assign is_subu   = is_r && (funct == 6'b100011);
  assign is_slt    = is_r && (funct == 6'b101010);
  assign r_valid   = is_addu || is_subu || is_slt;
  assign is_j      = (opcode == 6'b000010);
  assign is_beq    = (opcode == 6'b000100);
  assign is_bgezal = (opcode == 6'b000001) && (rt == 5'b10001);
  assign is_ori    = (opcode == 6'b001101);
  assign is_addi   = (opcode == 6'b001000);
  assign is_lw     = (opcode == 6'b100011);
  assign is_sw     = (opcode == 6'b101011);
  assign valid     = r_valid || is_j || is_beq || is_bgezal || is_ori || is_addi || is_lw || is_sw;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IF;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IF)
        ovf_q <= 1'b0;
      else if (state_q == S_EXE && is_addi)
        ovf_q <= overflow;
    end
  end

  always_comb begin
    state_d    = S_IF;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 2'b00;
    mem_to_reg = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 3'b000;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    instr_done = 1'b0;
    case (state_q)
      S_IF: begin
        ir_write = 1'b1;
        pc_write = 1'b1;
        state_d  = S_ID;
      end
      S_ID: begin
        if (is_j) begin
          pc_write   = 1'b1;
          pc_src     = 2'b10;
          instr_done = 1'b1;
        end else if (!valid) begin
          instr_done = 1'b1;
        end else begin
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        if (r_valid) begin
          alu_op  = is_subu ? 3'b001 : (is_slt ? 3'b011 : 3'b000);
          state_d = S_WB;
        end else if (is_ori) begin
          alu_src_b = 2'b10;
          alu_op    = 3'b010;
          state_d   = S_WB;
        end else if (is_addi) begin
          alu_src_b = 2'b01;
          alu_op    = 3'b100;
          state_d   = S_WB;
        end else if (is_lw || is_sw) begin
          alu_src_b = 2'b01;
          state_d   = S_MEM;
        end else if (is_beq) begin
          alu_op     = 3'b001;
          instr_done = 1'b1;
          if (zero) begin
            pc_write = 1'b1;
            pc_src   = 2'b01;
          end
        end else if (is_bgezal) begin
          alu_op     = 3'b101;
          instr_done = 1'b1;
          // Branch and link happen together, so the link write uses the PC+4 already in PC.
          if (condition_jdg) begin
            pc_write   = 1'b1;
            pc_src     = 2'b01;
            reg_write  = 1'b1;
            reg_dst    = 2'b10;
            mem_to_reg = 2'b10;
          end
        end else begin
          instr_done = 1'b1;
        end
      end
      S_MEM: begin
        if (is_lw) begin
          mem_read = 1'b1;
          state_d  = S_MWB;
        end else begin
          mem_write  = 1'b1;
          instr_done = 1'b1;
        end
      end
      S_WB: begin
        instr_done = 1'b1;
        if (is_addi && ovf_q) begin
`ifdef MC_CTRL_OVF_FLAG_EN
          reg_write  = 1'b1;
          reg_dst    = 2'b11;
          mem_to_reg = 2'b11;
`else
          reg_write  = 1'b0;
`endif
        end else begin
          reg_write = 1'b1;
          reg_dst   = is_r ? 2'b01 : 2'b00;
        end
      end
      S_MWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
        instr_done = 1'b1;
      end
      default: state_d = S_IF;
    endcase
    // Reset squashes every enable immediately, even mid-instruction.
    if (rst) begin
      pc_write   = 1'b0;
      pc_src     = 2'b00;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 2'b00;
      mem_to_reg = 2'b00;
      alu_src_b  = 2'b00;
      alu_op     = 3'b000;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      instr_done = 1'b0;
    end
  end

  assign state = rst ? 3'd0 : state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed self-checking bench for mc_ctrl: one instruction at a time, outputs checked every cycle.
// Honours MC_CTRL_OVF_FLAG_EN for the addi-overflow write-back expectation.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rt;
  logic       zero;
  logic       overflow;
  logic       condition_jdg;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic       mem_read;
  logic       mem_write;
  logic       instr_done;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;

  localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BGZ = 6'b000001, OP_ORI = 6'b001101, OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BAD = 6'b111111;
  localparam logic [5:0] F_ADDU = 6'b100001, F_SUBU = 6'b100011, F_SLT = 6'b101010;
  localparam logic [4:0] RT_BGZ = 5'b10001;

  mc_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .rt(rt),
    .zero(zero), .overflow(overflow), .condition_jdg(condition_jdg),
    .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .mem_read(mem_read), .mem_write(mem_write), .instr_done(instr_done), .state(state)
  );

  always #5 clk = ~clk;

  logic [19:0] obs;
  assign obs = {pc_write, pc_src, ir_write, reg_write, reg_dst, mem_to_reg,
                alu_src_b, alu_op, mem_read, mem_write, instr_done, state};

  // Field order: pc_write pc_src ir_write reg_write reg_dst mem_to_reg alu_src_b alu_op mem_read mem_write instr_done state
  function automatic logic [19:0] vec(input logic pw, input logic [1:0] ps, input logic irw, input logic rw,
                                      input logic [1:0] rd, input logic [1:0] mtr, input logic [1:0] asb,
                                      input logic [2:0] aop, input logic mr, input logic mw, input logic dn,
                                      input logic [2:0] st);
    return {pw, ps, irw, rw, rd, mtr, asb, aop, mr, mw, dn, st};
  endfunction

  task automatic applyStimulus(input logic r, input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rtv,
                               input logic z, input logic ov, input logic cj);
    @(negedge clk);
    rst = r; opcode = op; funct = fn; rt = rtv;
    zero = z; overflow = ov; condition_jdg = cj;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [19:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%b required=%b", tag, obs, expv);
    end
  endtask

  logic [19:0] v_if, v_id, v_zero;

  initial begin
    v_if   = vec(1, 2'b00, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0, 0, 3'd0);
    v_id   = vec(0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0, 0, 3'd1);
    v_zero = 20'd0;

    applyStimulus(1, OP_R, F_ADDU, 5'd0, 0, 0, 0); checkOutput("reset0", v_zero);
    applyStimulus(1, OP_R, F_ADDU, 5'd0, 0, 0, 0); checkOutput("reset1", v_zero);

    // addu
    applyStimulus(0, OP_R, F_ADDU, 5'd0, 0, 0, 0); checkOutput("addu_if", v_if);
    applyStimulus(0, OP_R, F_ADDU, 5'd0, 0, 0, 0); checkOutput("addu_id", v_id);
    applyStimulus(0, OP_R, F_ADDU, 5'd0, 0, 0, 0);
    checkOutput("addu_exe", vec(0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0, 0, 3'd2));
    applyStimulus(0, OP_R, F_ADDU, 5'd0, 0, 0, 0);
    checkOutput("addu_wb", vec(0, 2'b00, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 0, 0, 1, 3'd4));

    // subu and slt EXE ops
    applyStimulus(0, OP_R, F_SUBU, 5'd0, 0, 0, 0); checkOutput("subu_if", v_if);
    applyStimulus(0, OP_R, F_SUBU, 5'd0, 0, 0, 0); checkOutput("subu_id", v_id);
    applyStimulus(0, OP_R, F_SUBU, 5'd0, 0, 0, 0);
    checkOutput("subu_exe", vec(0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 3'b001, 0, 0, 0, 3'd2));
    applyStimulus(0, OP_R, F_SUBU, 5'd0, 0, 0, 0);
    checkOutput("subu_wb", vec(0, 2'b00, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 0, 0, 1, 3'd4));
    applyStimulus(0, OP_R, F_SLT, 5'd0, 0, 0, 0); checkOutput("slt_if", v_if);
    applyStimulus(0, OP_R, F_SLT, 5'd0, 0, 0, 0); checkOutput("slt_id", v_id);
    applyStimulus(0, OP_R, F_SLT, 5'd0, 0, 0, 0);
    checkOutput("slt_exe", vec(0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 3'b011, 0, 0, 0, 3'd2));
    applyStimulus(0, OP_R, F_SLT, 5'd0, 0, 0, 0);
    checkOutput("slt_wb", vec(0, 2'b00, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 0, 0, 1, 3'd4));

    // lw
    applyStimulus(0, OP_LW, 6'd0, 5'd0, 0, 0, 0); checkOutput("lw_if", v_if);
    applyStimulus(0, OP_LW, 6'd0, 5'd0, 0, 0, 0); checkOutput("lw_id", v_id);
    applyStimulus(0, OP_LW, 6'd0, 5'd0, 0, 0, 0);
    checkOutput("lw_exe", vec(0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b01, 3'b000, 0, 0, 0, 3'd2));
    applyStimulus(0, OP_LW, 6'd0, 5'd0, 0, 0, 0);
    checkOutput("lw_mem", vec(0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0, 0, 3'd3));
    applyStimulus(0, OP_LW, 6'd0, 5'd0, 0, 0, 0);
    checkOutput("lw_mwb", vec(0, 2'b00, 0, 1, 2'b00, 2'b01, 2'b00, 3'b000, 0, 0, 1, 3'd5));

    // sw
    applyStimulus(0, OP_SW, 6'd0, 5'd0, 0, 0, 0); checkOutput("sw_if", v_if);
    applyStimulus(0, OP_SW, 6'd0, 5'd0, 0, 0, 0); checkOutput("sw_id", v_id);
    applyStimulus(0, OP_SW, 6'd0, 5'd0, 0, 0, 0);
    checkOutput("sw_exe", vec(0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b01, 3'b000, 0, 0, 0, 3'd2));
    applyStimulus(0, OP_SW, 6'd0, 5'd0, 0, 0, 0);
    checkOutput("sw_mem", vec(0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 1, 1, 3'd3));

    // beq taken / not taken
    applyStimulus(0, OP_BEQ, 6'd0, 5'd0, 1, 0, 0); checkOutput("beqT_if", v_if);
    applyStimulus(0, OP_BEQ, 6'd0, 5'd0, 1, 0, 0); checkOutput("beqT_id", v_id);
    applyStimulus(0, OP_BEQ, 6'd0, 5'd0, 1, 0, 0);
    checkOutput("beqT_exe", vec(1, 2'b01, 0, 0, 2'b00, 2'b00, 2'b00, 3'b001, 0, 0, 1, 3'd2));
    applyStimulus(0, OP_BEQ, 6'd0, 5'd0, 0, 0, 0); checkOutput("beqN_if", v_if);
    applyStimulus(0, OP_BEQ, 6'd0, 5'd0, 0, 0, 0); checkOutput("beqN_id", v_id);
    applyStimulus(0, OP_BEQ, 6'd0, 5'd0, 0, 0, 0);
    checkOutput("beqN_exe", vec(0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 3'b001, 0, 0, 1, 3'd2));

    // bgezal taken / not taken
    applyStimulus(0, OP_BGZ, 6'd0, RT_BGZ, 0, 0, 1); checkOutput("bgzT_if", v_if);
    applyStimulus(0, OP_BGZ, 6'd0, RT_BGZ, 0, 0, 1); checkOutput("bgzT_id", v_id);
    applyStimulus(0, OP_BGZ, 6'd0, RT_BGZ, 0, 0, 1);
    checkOutput("bgzT_exe", vec(1, 2'b01, 0, 1, 2'b10, 2'b10, 2'b00, 3'b101, 0, 0, 1, 3'd2));
    applyStimulus(0, OP_BGZ, 6'd0, RT_BGZ, 0, 0, 0); checkOutput("bgzN_if", v_if);
    applyStimulus(0, OP_BGZ, 6'd0, RT_BGZ, 0, 0, 0); checkOutput("bgzN_id", v_id);
    applyStimulus(0, OP_BGZ, 6'd0, RT_BGZ, 0, 0, 0);
    checkOutput("bgzN_exe", vec(0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 3'b101, 0, 0, 1, 3'd2));

    // j
    applyStimulus(0, OP_J, 6'd0, 5'd0, 0, 0, 0); checkOutput("j_if", v_if);
    applyStimulus(0, OP_J, 6'd0, 5'd0, 0, 0, 0);
    checkOutput("j_id", vec(1, 2'b10, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0, 1, 3'd1));

    // ori
    applyStimulus(0, OP_ORI, 6'd0, 5'd0, 0, 0, 0); checkOutput("ori_if", v_if);
    applyStimulus(0, OP_ORI, 6'd0, 5'd0, 0, 0, 0); checkOutput("ori_id", v_id);
    applyStimulus(0, OP_ORI, 6'd0, 5'd0, 0, 0, 0);
    checkOutput("ori_exe", vec(0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b10, 3'b010, 0, 0, 0, 3'd2));
    applyStimulus(0, OP_ORI, 6'd0, 5'd0, 0, 0, 0);
    checkOutput("ori_wb", vec(0, 2'b00, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0, 1, 3'd4));

    // addi with overflow; flag dropped after EXE to show it was latched
    applyStimulus(0, OP_ADDI, 6'd0, 5'd0, 0, 1, 0); checkOutput("addiO_if", v_if);
    applyStimulus(0, OP_ADDI, 6'd0, 5'd0, 0, 1, 0); checkOutput("addiO_id", v_id);
    applyStimulus(0, OP_ADDI, 6'd0, 5'd0, 0, 1, 0);
    checkOutput("addiO_exe", vec(0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b01, 3'b100, 0, 0, 0, 3'd2));
    applyStimulus(0, OP_ADDI, 6'd0, 5'd0, 0, 0, 0);
`ifdef MC_CTRL_OVF_FLAG_EN
    checkOutput("addiO_wb", vec(0, 2'b00, 0, 1, 2'b11, 2'b11, 2'b00, 3'b000, 0, 0, 1, 3'd4));
`else
    checkOutput("addiO_wb", vec(0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0, 1, 3'd4));
`endif

    // addi without overflow: ovf_q must have been cleared
    applyStimulus(0, OP_ADDI, 6'd0, 5'd0, 0, 0, 0); checkOutput("addiN_if", v_if);
    applyStimulus(0, OP_ADDI, 6'd0, 5'd0, 0, 0, 0); checkOutput("addiN_id", v_id);
    applyStimulus(0, OP_ADDI, 6'd0, 5'd0, 0, 0, 0);
    checkOutput("addiN_exe", vec(0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b01, 3'b100, 0, 0, 0, 3'd2));
    applyStimulus(0, OP_ADDI, 6'd0, 5'd0, 0, 0, 0);
    checkOutput("addiN_wb", vec(0, 2'b00, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0, 1, 3'd4));

    // undefined opcode and undefined R funct
    applyStimulus(0, OP_BAD, 6'd0, 5'd0, 0, 0, 0); checkOutput("bad_if", v_if);
    applyStimulus(0, OP_BAD, 6'd0, 5'd0, 0, 0, 0);
    checkOutput("bad_id", vec(0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0, 1, 3'd1));
    applyStimulus(0, OP_R, 6'b111111, 5'd0, 0, 0, 0); checkOutput("badR_if", v_if);
    applyStimulus(0, OP_R, 6'b111111, 5'd0, 0, 0, 0);
    checkOutput("badR_id", vec(0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0, 1, 3'd1));

    // reset in the middle of lw while in MEM
    applyStimulus(0, OP_LW, 6'd0, 5'd0, 0, 0, 0); checkOutput("lwR_if", v_if);
    applyStimulus(0, OP_LW, 6'd0, 5'd0, 0, 0, 0); checkOutput("lwR_id", v_id);
    applyStimulus(0, OP_LW, 6'd0, 5'd0, 0, 0, 0);
    checkOutput("lwR_exe", vec(0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b01, 3'b000, 0, 0, 0, 3'd2));
    applyStimulus(1, OP_LW, 6'd0, 5'd0, 0, 0, 0); checkOutput("lwR_mem_rst", v_zero);
    applyStimulus(0, OP_LW, 6'd0, 5'd0, 0, 0, 0); checkOutput("lwR_after_if", v_if);
    applyStimulus(0, OP_LW, 6'd0, 5'd0, 0, 0, 0); checkOutput("lwR_after_id", v_id);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
